alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/yAlu.sv | 33 +++
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for alu_arbiter and its yAlu datapath.
//   - Opcode encodings understood by yAlu.
//   - FSM state encoding for the arbiter sequencer.
//   - is_legal_op(): true when an opcode has a defined ALU result.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/yAlu.sv
// yAlu: combinational ALU datapath.
//   a, b : WIDTH-bit operands
//   op   : 3-bit opcode (AND, OR, ADD, SUB; anything else yields z=0)
//   z    : WIDTH-bit result (ADD/SUB wrap modulo 2^WIDTH)
//   ex   : zero flag, high when z is all zeros
module yAlu
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = a + b;
      OP_SUB:  z = a - b;
      default: z = '0;
    endcase
  end

  assign ex = (z == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one yAlu between two requesters with round-robin grant.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready : per-port request handshake (bit i = port i)
//   req_a0/b0/op0       : port 0 operands and opcode
//   req_a1/b1/op1       : port 1 operands and opcode
//   rsp_valid/rsp_ready : per-port response handshake
//   rsp_z, rsp_ex       : registered ALU result and zero flag
//   rsp_err             : latched opcode was illegal (result forced to 0, ex=1)
//   busy                : sequencer not in IDLE
// Optional build macro ALU_ARBITER_STATS_EN adds saturating 16-bit counters
//   grant_cnt0, grant_cnt1 (accepts per port) and err_cnt (illegal ops).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_ex,
  output logic             rsp_err,
`ifdef ALU_ARBITER_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      err_cnt,
`endif
  output logic             busy
);

  state_t           state;
  logic             rr_ptr;
  logic             gid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;

  logic             req_any;
  logic             grant_id;
  logic             accept;
  logic             op_legal;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ex;

  // Grant: a lone requester wins outright; on contention rr_ptr decides.
  assign req_any  = |req_valid;
  assign grant_id = (&req_valid) ? rr_ptr : req_valid[1];
  assign accept   = (state == IDLE) && req_any;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // The ALU always sees the latched operands, even for illegal opcodes;
  // the result is overridden on capture instead.
  yAlu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .z  (alu_z),
    .ex (alu_ex)
  );

  assign op_legal = is_legal_op(op_q);

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      gid_q     <= 1'b0;
      // NOTE: the operand latches are reset as well so the ALU inputs are
      // never X; they are few flops, unlike a memory array.
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      rsp_valid <= '0;
      rsp_z     <= '0;
      rsp_ex    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            a_q    <= grant_id ? req_a1  : req_a0;
            b_q    <= grant_id ? req_b1  : req_b0;
            op_q   <= grant_id ? req_op1 : req_op0;
            gid_q  <= grant_id;
            rr_ptr <= ~grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_z     <= op_legal ? alu_z  : '0;
          rsp_ex    <= op_legal ? alu_ex : 1'b1;
          rsp_err   <= ~op_legal;
          rsp_valid <= gid_q ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          // Only the owning port's rsp_ready can release the response.
          if (rsp_ready[gid_q]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  logic err_event;
  assign err_event = (state == EXEC) && !op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept && !grant_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (accept &&  grant_id && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (err_event && err_cnt != 16'hFFFF)              err_cnt    <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (WIDTH=32).
// Build with ALU_ARBITER_STATS_EN defined to also check the statistics counters.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [2:0]       req_op0 = '0, req_op1 = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_ex, rsp_err, busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1, err_cnt;
`endif

  int tests = 0;
  int failed = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op0   (req_op0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_ex    (rsp_ex),
    .rsp_err   (rsp_err),
`ifdef ALU_ARBITER_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op);
    if (p == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end
  endtask

  // Single-port transaction with full latency and handshake checks.
  task automatic do_op(input string tag, input int p, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp_z, input logic exp_ex, input logic exp_err);
    logic [1:0] onehot;
    int n;
    onehot = (p == 0) ? 2'b01 : 2'b10;
    drive_port(p, a, b, op);
    req_valid = onehot;
    #1;
    n = 0;
    while (req_ready !== onehot && n < 20) begin
      step();
      n++;
    end
    if (n == 20) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      req_valid = '0;
      return;
    end
    check({tag, "_rdy"}, req_ready, onehot);
    step();                          // EXEC: no response yet
    req_valid = '0;
    check({tag, "_exec_vld"}, rsp_valid, 2'b00);
    check({tag, "_exec_busy"}, busy, 1'b1);
    step();                          // RESP: accept edge + 2
    check({tag, "_vld"}, rsp_valid, onehot);
    check({tag, "_z"}, rsp_z, exp_z);
    check({tag, "_ex"}, rsp_ex, exp_ex);
    check({tag, "_err"}, rsp_err, exp_err);
    rsp_ready = onehot;
    step();
    rsp_ready = '0;
    check({tag, "_done_vld"}, rsp_valid, 2'b00);
    check({tag, "_done_busy"}, busy, 1'b0);
    check({tag, "_hold_z"}, rsp_z, exp_z);
  endtask

  // Round-robin operand tables with hand-computed results.
  logic [31:0] a0_t [3] = '{32'hF0F0_F0F0, 32'h1234_0000, 32'hFFFF_0000};
  logic [31:0] b0_t [3] = '{32'h0FF0_0FF0, 32'h0000_5678, 32'h00FF_FF00};
  logic [2:0]  o0_t [3] = '{3'b000, 3'b001, 3'b000};
  logic [31:0] z0_t [3] = '{32'h00F0_00F0, 32'h1234_5678, 32'h00FF_0000};
  logic [31:0] a1_t [3] = '{32'hAAAA_AAAA, 32'h8000_0001, 32'h0000_0000};
  logic [31:0] b1_t [3] = '{32'h5555_5555, 32'h8000_0000, 32'h0000_0000};
  logic [2:0]  o1_t [3] = '{3'b001, 3'b000, 3'b001};
  logic [31:0] z1_t [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
  logic        e1_t [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int k0, k1, n;
    logic g;
    logic [31:0] ez;
    logic ee;

    // Reset values
    repeat (3) step();
    check("rst_vld", rsp_valid, 2'b00);
    check("rst_z", rsp_z, 32'd0);
    check("rst_ex", rsp_ex, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset in the middle of EXEC discards the op
    drive_port(0, 32'd1, 32'd2, 3'b010);
    req_valid = 2'b01;
    #1;
    check("mid_rdy", req_ready, 2'b01);
    step();
    req_valid = '0;
    check("mid_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_vld", rsp_valid, 2'b00);
    check("mid_rst_z", rsp_z, 32'd0);
    step();
    step();
    check("mid_rst_vld2", rsp_valid, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op("post_rst_p1", 1, 32'd9, 32'd4, 3'b001, 32'd13, 1'b0, 1'b0);

    // Basic arithmetic
    do_op("add_p0", 0, 32'd7, 32'd5, 3'b010, 32'd12, 1'b0, 1'b0);
    do_op("sub_zero", 1, 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0);
    do_op("sub_wrap", 1, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Round robin under continuous contention (rr_ptr is 0 here)
    k0 = 0; k1 = 0;
    drive_port(0, a0_t[0], b0_t[0], o0_t[0]);
    drive_port(1, a1_t[0], b1_t[0], o1_t[0]);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        step();
        n++;
      end
      if (n == 20) begin
        check("rr_timeout", 64'd0, 64'd1);
        break;
      end
      check($sformatf("rr%0d_grant", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      g = req_ready[1];
      if (g) begin
        ez = z1_t[k1]; ee = e1_t[k1];
      end else begin
        ez = z0_t[k0]; ee = 1'b0;
      end
      step();                        // EXEC
      check($sformatf("rr%0d_busy_rdy", i), req_ready, 2'b00);
      if (g) begin
        k1++;
        if (k1 < 3) drive_port(1, a1_t[k1], b1_t[k1], o1_t[k1]);
        else req_valid[1] = 1'b0;
      end else begin
        k0++;
        if (k0 < 3) drive_port(0, a0_t[k0], b0_t[k0], o0_t[k0]);
        else req_valid[0] = 1'b0;
      end
      step();                        // RESP
      check($sformatf("rr%0d_vld", i), rsp_valid, g ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_z", i), rsp_z, ez);
      check($sformatf("rr%0d_ex", i), rsp_ex, ee);
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
      #1;
    end
    req_valid = '0;

    // Backpressure, with the non-granted rsp_ready bit asserted
    drive_port(0, 32'd100, 32'd23, 3'b010);
    drive_port(1, 32'd6, 32'd3, 3'b110);
    req_valid = 2'b11;
    #1;
    check("bp_grant", req_ready, 2'b01);
    step();
    step();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_vld", i), rsp_valid, 2'b01);
      check($sformatf("bp%0d_z", i), rsp_z, 32'd123);
      check($sformatf("bp%0d_busy", i), busy, 1'b1);
      check($sformatf("bp%0d_rdy", i), req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    step();
    rsp_ready = 2'b00;
    check("bp_next_rdy", req_ready, 2'b10);
    step();
    req_valid = '0;
    step();
    check("bp_p1_vld", rsp_valid, 2'b10);
    check("bp_p1_z", rsp_z, 32'd3);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;

    // Illegal opcode
    do_op("illegal", 0, 32'd3, 32'd4, 3'b011, 32'd0, 1'b1, 1'b1);

`ifdef ALU_ARBITER_STATS_EN
    check("err_cnt", err_cnt, 16'd1);
    check("grant_cnt0", grant_cnt0, 16'd6);
    check("grant_cnt1", grant_cnt1, 16'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
